// File: rtl/numberle_pkg.sv
// Shared definitions for the Numberle guess entry and display blocks:
// digit count, blank code, controller state encoding and anode patterns.
package numberle_pkg;

  localparam int          NUM_DIGITS  = 4;
  localparam logic [3:0]  BLANK_DIGIT = 4'hF;
  localparam logic [3:0]  ANODE_OFF   = 4'b1111;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    FULL   = 2'd1,
    SUBMIT = 2'd2
  } entry_state_e;

  // Active-low one-hot enable for a slot; slot0 sits on the leftmost digit (anode[3]).
  function automatic logic [3:0] anode_for(input logic [1:0] slot);
    logic [3:0] pat;
    case (slot)
      2'd0:    pat = 4'b0111;
      2'd1:    pat = 4'b1011;
      2'd2:    pat = 4'b1101;
      2'd3:    pat = 4'b1110;
      default: pat = ANODE_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Time-multiplexes a 4-nibble buffer onto a shared 4-digit seven-segment
// display. Slots holding the blank code are left dark. Outputs are registered.
module seg_scan_mux
  import numberle_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] digits_i,
  output logic [3:0]  anode_o,
  output logic [3:0]  hex_o
);

  localparam int                CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [3:0]       anode_q;
  logic [3:0]       hex_q;
  logic [3:0]       sel_digit_s;

  // Pick the nibble addressed by the current scan index.
  always_comb begin
    sel_digit_s = digits_i[{idx_q, 2'b00} +: 4];
  end

  // Dwell counter and scan index: advance to the next digit at terminal count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Registered display drive; blank slots keep every digit dark.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      anode_q <= ANODE_OFF;
      hex_q   <= BLANK_DIGIT;
    end else if (sel_digit_s != BLANK_DIGIT) begin
      anode_q <= anode_for(idx_q);
      hex_q   <= sel_digit_s;
    end else begin
      anode_q <= ANODE_OFF;
      hex_q   <= BLANK_DIGIT;
    end
  end

  assign anode_o = anode_q;
  assign hex_o   = hex_q;

endmodule

// File: rtl/guess_entry_controller.sv
// Numberle guess entry: keypad digit buffer with cursor, backspace and submit,
// valid/ready hand-off to the checker, and scanned display of the buffer.
// Optional macro PARTIAL_SUBMIT_EN: allows submitting a partly filled guess
// from ENTRY (cursor >= 1); unfilled slots go out as blank.
module guess_entry_controller
  import numberle_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        key_back,
  input  logic        key_enter,
  output logic        guess_valid,
  output logic [15:0] guess,
  input  logic        guess_ready,
  output logic [2:0]  cursor,
  output logic [3:0]  anode,
  output logic [3:0]  hex_out
);

  entry_state_e                      state_q;
  logic [NUM_DIGITS-1:0][3:0]        slots_q;
  logic [2:0]                        cursor_q;
  logic                              guess_valid_q;
  logic [1:0]                        back_idx_s;

  // Slot vacated by a backspace in ENTRY (cursor is 1..3 whenever it is used).
  always_comb begin
    back_idx_s = cursor_q[1:0] - 2'd1;
  end

  // Entry FSM: buffer, cursor and guess_valid all update here.
  // Event priority is enter > back > digit; lower-priority events are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ENTRY;
      slots_q       <= {NUM_DIGITS{BLANK_DIGIT}};
      cursor_q      <= 3'd0;
      guess_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ENTRY: begin
          if (key_enter) begin
`ifdef PARTIAL_SUBMIT_EN
            if (cursor_q != 3'd0) begin
              state_q       <= SUBMIT;
              guess_valid_q <= 1'b1;
            end else begin
              state_q <= ENTRY;
            end
`else
            state_q <= ENTRY;
`endif
          end else if (key_back) begin
            if (cursor_q != 3'd0) begin
              cursor_q            <= cursor_q - 3'd1;
              slots_q[back_idx_s] <= BLANK_DIGIT;
            end else begin
              cursor_q <= 3'd0;
            end
          end else if (key_valid && (key_code <= 4'd9)) begin
            slots_q[cursor_q[1:0]] <= key_code;
            cursor_q               <= cursor_q + 3'd1;
            if (cursor_q == 3'd3) begin
              state_q <= FULL;
            end else begin
              state_q <= ENTRY;
            end
          end else begin
            state_q <= ENTRY;
          end
        end
        FULL: begin
          if (key_enter) begin
            state_q       <= SUBMIT;
            guess_valid_q <= 1'b1;
          end else if (key_back) begin
            slots_q[3] <= BLANK_DIGIT;
            cursor_q   <= 3'd3;
            state_q    <= ENTRY;
          end else begin
            state_q <= FULL;
          end
        end
        SUBMIT: begin
          if (guess_valid_q && guess_ready) begin
            guess_valid_q <= 1'b0;
            slots_q       <= {NUM_DIGITS{BLANK_DIGIT}};
            cursor_q      <= 3'd0;
            state_q       <= ENTRY;
          end else begin
            state_q <= SUBMIT;
          end
        end
        default: begin
          state_q       <= ENTRY;
          slots_q       <= {NUM_DIGITS{BLANK_DIGIT}};
          cursor_q      <= 3'd0;
          guess_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign guess       = slots_q;
  assign cursor      = cursor_q;
  assign guess_valid = guess_valid_q;

  seg_scan_mux #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .digits_i (slots_q),
    .anode_o  (anode),
    .hex_o    (hex_out)
  );

endmodule

// File: tb/tb_guess_entry_controller.sv
// Directed self-checking bench for guess_entry_controller (SCAN_DIV = 4).
module tb_guess_entry_controller;

  logic        clock;
  logic        reset_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_back;
  logic        key_enter;
  logic        guess_valid;
  logic [15:0] guess;
  logic        guess_ready;
  logic [2:0]  cursor;
  logic [3:0]  anode;
  logic [3:0]  hex_out;

  int n_checks = 0;
  int n_pass   = 0;
  int xfer_cnt = 0;

  guess_entry_controller #(.SCAN_DIV(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_back    (key_back),
    .key_enter   (key_enter),
    .guess_valid (guess_valid),
    .guess       (guess),
    .guess_ready (guess_ready),
    .cursor      (cursor),
    .anode       (anode),
    .hex_out     (hex_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count completed handshakes as seen on the clock edge.
  always @(posedge clock) begin
    if (reset_n && guess_valid && guess_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1; key_code = code;
    @(negedge clock);
    key_valid = 1'b0; key_code = 4'h0;
  endtask

  task automatic back();
    key_back = 1'b1;
    @(negedge clock);
    key_back = 1'b0;
  endtask

  task automatic enter();
    key_enter = 1'b1;
    @(negedge clock);
    key_enter = 1'b0;
  endtask

  logic [3:0] exp_an [20];
  logic [3:0] exp_hx [20];
  logic [3:0] prev_an;
  bit         synced;
  int         x0;

  initial begin
    reset_n = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    key_back = 1'b0; key_enter = 1'b0; guess_ready = 1'b0;
    idle(2);
    // Reset state
    check("rst_guess",  guess, 32'hFFFF);
    check("rst_cursor", cursor, 32'd0);
    check("rst_valid",  guess_valid, 32'd0);
    check("rst_anode",  anode, 32'hF);
    check("rst_hex",    hex_out, 32'hF);
    reset_n = 1'b1;
    idle(1);

    // Entry 3,1,4,1 fills the buffer; a fifth digit is ignored
    press(4'd3); press(4'd1); press(4'd4); press(4'd1);
    check("fill_guess",  guess, 32'h1413);
    check("fill_cursor", cursor, 32'd4);
    press(4'd9);
    check("full_nowrap_guess",  guess, 32'h1413);
    check("full_nowrap_cursor", cursor, 32'd4);
    // Non-digit code in ENTRY is ignored (after one back)
    back();
    check("full_back_guess",  guess, 32'hF413);
    check("full_back_cursor", cursor, 32'd3);
    press(4'hB);
    check("badcode_guess", guess, 32'hF413);
    back(); back(); back();
    check("clear_guess",  guess, 32'hFFFF);
    check("clear_cursor", cursor, 32'd0);

    // Backspace
    press(4'd7); press(4'd2); back();
    check("bs_guess",  guess, 32'hFFF7);
    check("bs_cursor", cursor, 32'd1);
    back(); back();
    check("bs_uflow_guess",  guess, 32'hFFFF);
    check("bs_uflow_cursor", cursor, 32'd0);

    // Handshake with ready held low
    press(4'd5); press(4'd6); press(4'd7); press(4'd8);
    enter();
    check("hs_valid_rise", guess_valid, 32'd1);
    press(4'd1); back();
    idle(8);
    check("hs_valid_hold", guess_valid, 32'd1);
    check("hs_guess_hold", guess, 32'h8765);
    check("hs_no_xfer", xfer_cnt, 32'd0);
    guess_ready = 1'b1;
    @(negedge clock);
    guess_ready = 1'b0;
    check("hs_valid_fall", guess_valid, 32'd0);
    check("hs_guess_clr",  guess, 32'hFFFF);
    check("hs_cursor_clr", cursor, 32'd0);
    idle(2);
    check("hs_one_xfer", xfer_cnt, 32'd1);

    // Priority in FULL: enter wins; ready already high completes at once
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    guess_ready = 1'b1;
    key_valid = 1'b1; key_code = 4'd2; key_back = 1'b1; key_enter = 1'b1;
    @(negedge clock);
    key_valid = 1'b0; key_back = 1'b0; key_enter = 1'b0;
    check("prio_valid",  guess_valid, 32'd1);
    check("prio_guess",  guess, 32'h4321);
    check("prio_cursor", cursor, 32'd4);
    @(negedge clock);
    guess_ready = 1'b0;
    check("prio_xfer_valid", guess_valid, 32'd0);
    check("prio_xfer_guess", guess, 32'hFFFF);
    check("prio_xfer_cnt",   xfer_cnt, 32'd2);

    // Scan: buffer FF21 -> slot0 '1', slot1 '2', slots 2/3 dark, 4 cycles each
    press(4'd1); press(4'd2);
    for (int i = 0; i < 20; i++) begin
      case ((i / 4) % 4)
        0:       begin exp_an[i] = 4'b0111; exp_hx[i] = 4'h1; end
        1:       begin exp_an[i] = 4'b1011; exp_hx[i] = 4'h2; end
        default: begin exp_an[i] = 4'b1111; exp_hx[i] = 4'hF; end
      endcase
    end
    synced = 1'b0;
    prev_an = anode;
    for (int i = 0; i < 64 && !synced; i++) begin
      @(negedge clock);
      if (prev_an == 4'b1111 && anode == 4'b0111) synced = 1'b1;
      prev_an = anode;
    end
    check("scan_sync", {31'd0, synced}, 32'd1);
    if (synced) begin
      for (int i = 0; i < 20; i++) begin
        check($sformatf("scan_%0d", i), {anode, hex_out}, {exp_an[i], exp_hx[i]});
        @(negedge clock);
      end
    end
    back(); back();
    check("scan_clear", guess, 32'hFFFF);

    // Asynchronous reset mid-SUBMIT
    press(4'd5); press(4'd6); press(4'd7); press(4'd8);
    enter();
    idle(4);
    check("ar_valid_pre", guess_valid, 32'd1);
    x0 = xfer_cnt;
    #2 reset_n = 1'b0;
    #1;
    check("ar_valid",  guess_valid, 32'd0);
    check("ar_anode",  anode, 32'hF);
    check("ar_guess",  guess, 32'hFFFF);
    check("ar_cursor", cursor, 32'd0);
    @(negedge clock);
    guess_ready = 1'b1;
    reset_n = 1'b1;
    idle(2);
    guess_ready = 1'b0;
    check("ar_no_xfer", xfer_cnt, x0);
    check("ar_valid_post", guess_valid, 32'd0);

    // Enter at cursor 0 is always ignored
    enter();
    check("enter_empty", guess_valid, 32'd0);
    // Partial submit
    press(4'd9);
    enter();
`ifdef PARTIAL_SUBMIT_EN
    check("partial_valid", guess_valid, 32'd1);
    check("partial_guess", guess, 32'hFFF9);
`else
    check("partial_valid", guess_valid, 32'd0);
    check("partial_guess", guess, 32'hFFF9);
    check("partial_cursor", cursor, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/guess_entry_controller.md
Name: guess_entry_controller

Overview:
- Sequences player digit entry for the Numberle guess and schedules the shared 4-digit seven-segment display.
- Accepts single-cycle key events from the keypad decoder and keeps a 4-nibble guess buffer with a write cursor.
- Supports backspace and submit, and hands a complete guess to the checker over a valid/ready handshake.
- Time-multiplexes the buffer onto anode/hex_out and blanks empty slots.

Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays lit before the scan advances. Legal range is 2 to 2^20.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe; key_code is valid in that cycle.
- key_code  in  4  digit 0x0-0x9. Codes 0xA-0xF are ignored.
- key_back  in  1  one-cycle backspace strobe.
- key_enter  in  1  one-cycle submit strobe.
- guess_valid  out  1  a complete guess is offered to the checker.
- guess  out  16  slot0 = [3:0] … slot3 = [15:12]; 0xF means blank.
- guess_ready  in  1  checker accepts the guess when guess_ready and guess_valid are both high.
- cursor  out  3  number of digits entered, 0..4.
- anode  out  4  active-low digit enables; slot0 drives anode[3].
- hex_out  out  4  nibble for the lit digit, sent to the segment decoder.

Behaviour:
- Reset (asynchronous, on reset_n low):
  - all slots = 0xF, cursor = 0, state = ENTRY, guess_valid = 0.
  - anode = 4'b1111, hex_out = 0xF, scan index = 0, scan counter = 0.
  - Reset asserted mid-submit drops guess_valid immediately; no handshake completes.
- States: ENTRY (cursor<4), FULL (cursor==4), SUBMIT.
- Event priority within one cycle: key_enter > key_back > key_valid. Only the highest-priority asserted event acts; the others are dropped.
- ENTRY:
  - key_valid with code ≤9 writes slot[cursor] and increments cursor, effective next cycle.
  - Reaching cursor=4 moves the state to FULL.
  - key_back with cursor>0 decrements cursor and sets the vacated slot to 0xF.
  - key_back at cursor=0 does nothing.
  - key_enter is ignored (see the optional feature).
- FULL:
  - key_valid is ignored; the buffer does not wrap.
  - key_back clears slot3, sets cursor=3 and returns to ENTRY.
  - key_enter moves to SUBMIT; guess_valid rises the next cycle.
- SUBMIT:
  - guess_valid = 1; guess is held stable while valid.
  - All key inputs are ignored.
  - On the cycle where guess_valid and guess_ready are both high: next cycle guess_valid = 0, all slots = 0xF, cursor = 0, state = ENTRY.
  - guess_ready is ignored outside SUBMIT. A guess_ready that is already high completes the handshake in the first valid cycle.
- guess always mirrors the buffer registers, so it has zero latency from buffer updates.
- Scan:
  - Counter runs 0..SCAN_DIV-1. At terminal count it wraps to 0 and the scan index advances 0→1→2→3→0.
  - anode/hex_out are registered and update one cycle after the index or buffer changes.
  - For index i, if slot[i] ≠ 0xF: anode has bit (3-i) low, the other bits high, and hex_out = slot[i].
  - For index i, if slot[i] = 0xF: anode = 4'b1111 and hex_out = 0xF.
  - At most one anode is low in any cycle.

Optional Feature:
- Macro: PARTIAL_SUBMIT_EN.
- Defined: key_enter in ENTRY with cursor ≥1 moves to SUBMIT; unfilled slots are sent as 0xF. With cursor = 0, key_enter is ignored.
- Undefined: key_enter is honoured only in FULL.

Decomposition:
- numberle_pkg holds:
  - NUM_DIGITS = 4 and BLANK_DIGIT = 4'hF.
  - the state encoding (ENTRY=2'd0, FULL=2'd1, SUBMIT=2'd2).
  - the anode one-hot-low patterns per slot.
- Sub-module seg_scan_mux holds the scan counter, index, blanking and output registers.
  - Inputs: the 16-bit buffer. Parameter: SCAN_DIV.
  - Reused later by the feedback display.

Test Plan:
- Entry: reset, keys 3,1,4,1 → guess=16'h1413, cursor=4, FULL; a further key 9 leaves guess unchanged.
- Backspace: keys 7,2 then key_back → guess=16'hFFF7, cursor=1. Two more key_back → cursor=0, no underflow.
- Handshake: fill 5,6,7,8, key_enter, guess_ready held low 10 cycles → guess_valid stays 1 and guess=16'h8765. Raise ready → one transfer, then guess=16'hFFFF, cursor=0.
- Priority: key_valid(2), key_back and key_enter in the same cycle while FULL → enters SUBMIT, buffer unchanged.
- Scan (SCAN_DIV=4): buffer 16'hFF21 → anode 0111/hex 1, then 1011/hex 2, then 1111, 1111, each for 4 cycles, then repeat.
- Reset mid-SUBMIT: drop reset_n asynchronously → guess_valid=0 and anode=1111 before the next clock edge. With PARTIAL_SUBMIT_EN: key 9 then enter → guess=16'hFFF9 valid.
